// File: rtl/dimc_psum_collector.sv
// -----------------------------------------------------------------------------
// dimc_psum_collector
//   Downstream stage of the DIMC macro. Every RCK edge with READYN low is one
//   DIMC result. cfg_tiles consecutive partial sums (one per row tile) are
//   summed into one signed ACC_W word. Finished words are queued in a small
//   FIFO and handed to the vector processor over a valid/ready port. One
//   result per RCK cycle is sustained with no bubbles.
//
//   Optional feature: define DIMC_COLLECT_SAT_EN to saturate every add to the
//   signed ACC_W range instead of wrapping. ovf is raised in both builds.
//
// Ports
//   RCK         in   clock, all logic on posedge
//   RESETn      in   synchronous reset, active-low
//   READYN      in   DIMC result valid, active-low
//   PSOUT       in   DIMC partial sum, signed PSUM_W
//   RES_OUT     in   DIMC result bits (3)
//   SOUT        in   DIMC sign/serial bit
//   cfg_tiles   in   partial sums per output word, 0 treated as 1
//   clear       in   abort current group (acc and tile counter to 0)
//   out_valid   out  FIFO non-empty
//   out_ready   in   consumer accepts head when out_valid & out_ready
//   out_data    out  FIFO head word, 0 when empty
//   out_flags   out  {RES_OUT,SOUT} of the head word's final tile, 0 when empty
//   fifo_count  out  FIFO occupancy
//   busy        out  group in progress
//   ovf         out  sticky signed-overflow flag
//   drop        out  sticky lost-word flag (push into a full FIFO)
// -----------------------------------------------------------------------------
module dimc_psum_collector #(
  parameter int PSUM_W     = 24,
  parameter int ACC_W      = 32,
  parameter int TILES_W    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          RCK,
  input  logic                          RESETn,
  input  logic                          READYN,
  input  logic [PSUM_W-1:0]             PSOUT,
  input  logic [2:0]                    RES_OUT,
  input  logic                          SOUT,
  input  logic [TILES_W-1:0]            cfg_tiles,
  input  logic                          clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_W-1:0]              out_data,
  output logic [3:0]                    out_flags,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          ovf,
  output logic                          drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ACC_W + 4;

  // Signed ACC_W add; returns {overflow, result}. The result wraps or
  // saturates depending on the build.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] s;
    logic             o;
    s = a + b;
    o = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
`ifdef DIMC_COLLECT_SAT_EN
    if (o) begin
      // Both operands share a sign on overflow; clamp toward that sign.
      s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      s = s;
    end
`endif
    return {o, s};
  endfunction

  // State
  logic [TILES_W-1:0] tile_cnt_q, tile_cnt_d;
  logic [TILES_W-1:0] n_tiles_q, n_tiles_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               drop_q, drop_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];

  // Datapath helpers
  logic [ACC_W-1:0]   sext_s;
  logic [ACC_W:0]     add_res_s;
  logic [ACC_W-1:0]   sum_s;
  logic               first_s;
  logic               last_s;
  logic               sample_s;
  logic [TILES_W-1:0] eff_tiles_s;
  logic               push_s;
  logic               push_ok_s;
  logic               pop_s;
  logic               full_s;
  logic               nonempty_s;

  // Sample qualification, tile accounting, FIFO push/pop decisions.
  always_comb begin
    sext_s      = {{(ACC_W-PSUM_W){PSOUT[PSUM_W-1]}}, PSOUT};
    sample_s    = ~READYN & ~clear;           // clear wins over a sample
    first_s     = (tile_cnt_q == {TILES_W{1'b0}});
    // cfg_tiles is only honoured at the first tile of a group
    if (first_s) begin
      eff_tiles_s = (cfg_tiles == {TILES_W{1'b0}}) ? TILES_W'(1) : cfg_tiles;
    end else begin
      eff_tiles_s = n_tiles_q;
    end
    add_res_s   = acc_add(acc_q, sext_s);
    sum_s       = first_s ? sext_s : add_res_s[ACC_W-1:0];
    last_s      = (tile_cnt_q == (eff_tiles_s - TILES_W'(1)));
    nonempty_s  = (count_q != {CNT_W{1'b0}});
    full_s      = (count_q == CNT_W'(FIFO_DEPTH));
    pop_s       = nonempty_s & out_ready;
    push_s      = sample_s & last_s;
    push_ok_s   = push_s & (~full_s | pop_s);

    tile_cnt_d  = tile_cnt_q;
    n_tiles_d   = n_tiles_q;
    acc_d       = acc_q;
    if (clear) begin
      tile_cnt_d = {TILES_W{1'b0}};
      acc_d      = {ACC_W{1'b0}};
    end else if (sample_s) begin
      acc_d = sum_s;
      if (first_s) begin
        n_tiles_d = eff_tiles_s;
      end else begin
        n_tiles_d = n_tiles_q;
      end
      if (last_s) begin
        tile_cnt_d = {TILES_W{1'b0}};
      end else begin
        tile_cnt_d = tile_cnt_q + TILES_W'(1);
      end
    end else begin
      tile_cnt_d = tile_cnt_q;
    end

    // The first tile is a plain load, so it can never overflow.
    ovf_d    = ovf_q | (sample_s & ~first_s & add_res_s[ACC_W]);
    drop_d   = drop_q | (push_s & full_s & ~pop_s);

    wr_ptr_d = push_ok_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_s);
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge RCK) begin
    if (!RESETn) begin
      tile_cnt_q <= {TILES_W{1'b0}};
      n_tiles_q  <= {TILES_W{1'b0}};
      acc_q      <= {ACC_W{1'b0}};
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
    end else begin
      tile_cnt_q <= tile_cnt_d;
      n_tiles_q  <= n_tiles_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are qualified by count_q so no reset is needed.
  always_ff @(posedge RCK) begin
    if (RESETn && push_ok_s) begin
      mem_q[wr_ptr_q] <= {sum_s, RES_OUT, SOUT};
    end
  end

  // Output view of the registered state; the head is forced to 0 when empty.
  always_comb begin
    out_valid  = nonempty_s;
    if (nonempty_s) begin
      out_data  = mem_q[rd_ptr_q][ENT_W-1:4];
      out_flags = mem_q[rd_ptr_q][3:0];
    end else begin
      out_data  = {ACC_W{1'b0}};
      out_flags = 4'b0000;
    end
    fifo_count = count_q;
    busy       = ~first_s;
    ovf        = ovf_q;
    drop       = drop_q;
  end

endmodule

// File: tb/tb_dimc_psum_collector.sv
module tb_dimc_psum_collector;

  localparam int PW = 24;
  localparam int AW = 32;
  localparam int TW = 4;
  localparam int FD = 8;
  localparam longint AMAX = (64'sd1 <<< (AW-1)) - 64'sd1;
  localparam longint AMIN = -(64'sd1 <<< (AW-1));

  logic RCK = 1'b0;
  always #5 RCK = ~RCK;

  // Main DUT (ACC_W = 32)
  logic          RESETn = 1'b0;
  logic          READYN = 1'b1;
  logic [PW-1:0] PSOUT = '0;
  logic [2:0]    RES_OUT = '0;
  logic          SOUT = 1'b0;
  logic [TW-1:0] cfg_tiles = '0;
  logic          clear = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [AW-1:0] out_data;
  logic [3:0]    out_flags;
  logic [3:0]    fifo_count;
  logic          busy, ovf, drop;

  dimc_psum_collector #(.PSUM_W(PW), .ACC_W(AW), .TILES_W(TW), .FIFO_DEPTH(FD)) dut (
    .RCK(RCK), .RESETn(RESETn), .READYN(READYN), .PSOUT(PSOUT), .RES_OUT(RES_OUT),
    .SOUT(SOUT), .cfg_tiles(cfg_tiles), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .fifo_count(fifo_count), .busy(busy), .ovf(ovf), .drop(drop));

  // Narrow-accumulator instance for the overflow case (ACC_W = 25)
  logic          r25_rstn = 1'b0;
  logic          r25_readyn = 1'b1;
  logic [PW-1:0] r25_ps = '0;
  logic          v25, busy25, ovf25, drop25;
  logic [24:0]   d25;
  logic [3:0]    f25, c25;

  dimc_psum_collector #(.PSUM_W(PW), .ACC_W(25), .TILES_W(TW), .FIFO_DEPTH(FD)) dut25 (
    .RCK(RCK), .RESETn(r25_rstn), .READYN(r25_readyn), .PSOUT(r25_ps), .RES_OUT(3'b000),
    .SOUT(1'b0), .cfg_tiles(4'd3), .clear(1'b0), .out_valid(v25),
    .out_ready(1'b0), .out_data(d25), .out_flags(f25),
    .fifo_count(c25), .busy(busy25), .ovf(ovf25), .drop(drop25));

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_tcnt = 0;
  int          m_ntiles = 1;
  longint      m_acc = 0;
  longint      m_qd[$];
  logic [3:0]  m_qf[$];
  bit          m_ovf = 1'b0;
  bit          m_drop = 1'b0;

  function automatic longint m_add(input longint a, input longint b);
    longint s;
    s = a + b;
    if (s > AMAX || s < AMIN) begin
      m_ovf = 1'b1;
`ifdef DIMC_COLLECT_SAT_EN
      s = (s > AMAX) ? AMAX : AMIN;
`else
      s = s & ((64'sd1 <<< AW) - 64'sd1);
      if (s > AMAX) s = s - (64'sd1 <<< AW);
`endif
    end
    return s;
  endfunction

  // Advance the model by one RCK edge using the inputs currently driven.
  task automatic model_step();
    bit     pop, full, push;
    longint sv, v;
    if (!RESETn) begin
      m_tcnt = 0; m_ntiles = 1; m_acc = 0; m_ovf = 1'b0; m_drop = 1'b0;
      m_qd.delete(); m_qf.delete();
      return;
    end
    pop  = (m_qd.size() > 0) && out_ready;
    full = (m_qd.size() == FD);
    push = 1'b0;
    v    = 0;
    if (clear) begin
      m_tcnt = 0; m_acc = 0;
    end else if (!READYN) begin
      sv = longint'($signed(PSOUT));
      if (m_tcnt == 0) begin
        m_ntiles = (cfg_tiles == 0) ? 1 : int'(cfg_tiles);
        v = sv;
      end else begin
        v = m_add(m_acc, sv);
      end
      if (m_tcnt == m_ntiles - 1) begin
        push = 1'b1; m_tcnt = 0;
      end else begin
        m_acc = v; m_tcnt++;
      end
    end
    if (pop) begin
      void'(m_qd.pop_front()); void'(m_qf.pop_front());
    end
    if (push) begin
      if (full && !pop) m_drop = 1'b1;
      else begin
        m_qd.push_back(v); m_qf.push_back({RES_OUT, SOUT});
      end
    end
  endtask

  // Compare process: DUT state after each edge against the model.
  always @(negedge RCK) begin
    logic [AW-1:0] ed;
    logic [3:0]    ef;
    if (chk_en) begin
      ed = '0; ef = '0;
      if (m_qd.size() > 0) begin
        ed = m_qd[0][AW-1:0];
        ef = m_qf[0];
      end
      chk("out_valid", out_valid, m_qd.size() > 0);
      chk("out_data", out_data, ed);
      chk("out_flags", out_flags, ef);
      chk("fifo_count", fifo_count, m_qd.size());
      chk("busy", busy, m_tcnt != 0);
      chk("ovf", ovf, m_ovf);
      chk("drop", drop, m_drop);
    end
  end

  // One cycle of stimulus, applied between edges.
  task automatic cyc(input bit rn, input bit rdy, input bit clr, input bit rst,
                     input logic [PW-1:0] ps, input logic [2:0] res, input bit so,
                     input logic [TW-1:0] cfg);
    @(negedge RCK); #1;
    READYN = rn; out_ready = rdy; clear = clr; RESETn = rst;
    PSOUT = ps; RES_OUT = res; SOUT = so; cfg_tiles = cfg;
    model_step();
    chk_en = 1'b1;
  endtask

  task automatic samp(input logic [PW-1:0] ps, input logic [TW-1:0] cfg);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, ps, 3'b000, 1'b0, cfg);
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b1, rdy, 1'b0, 1'b1, '0, 3'b000, 1'b0, 4'd1);
  endtask

  task automatic settle();
    @(posedge RCK); #2;
  endtask

  int drain_exp[8] = '{2, 3, 4, 5, 6, 7, 8, 100};

  initial begin
    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 3'b000, 1'b0, 4'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 3'b000, 1'b0, 4'd1);
    settle();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", fifo_count, 4'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", busy, 1'b0);

    // T1: single-tile word with flags
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'd1024, 3'b111, 1'b1, 4'd1);
    settle();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 32'd1024);
    chk("t1_flags", out_flags, 4'b1111);
    idle(1'b1);
    settle();
    chk("t1_empty_flags", out_flags, 4'b0000);

    // T2: four tiles summed, busy during the group
    for (int i = 1; i <= 4; i++) begin
      samp(PW'(i), 4'd4);
      settle();
      if (i < 4) begin
        chk("t2_busy", busy, 1'b1);
        chk("t2_novalid", out_valid, 1'b0);
      end else begin
        chk("t2_busy_end", busy, 1'b0);
        chk("t2_data", out_data, 32'd10);
        chk("t2_count", fifo_count, 4'd1);
      end
    end
    idle(1'b1);

    // T3: sign extension
    samp(24'hFFFFFF, 4'd2);
    samp(24'd5, 4'd2);
    samp(24'h800000, 4'd2);
    samp(24'd0, 4'd2);
    settle();
    chk("t3_count", fifo_count, 4'd2);
    chk("t3_data0", out_data, 32'd4);
    idle(1'b1);
    settle();
    chk("t3_data1", out_data, 32'hFF800000);
    idle(1'b1);

    // T4: fill, drop, push+pop while full, drain in order
    for (int i = 1; i <= 9; i++) samp(PW'(i), 4'd1);
    settle();
    chk("t4_count", fifo_count, 4'd8);
    chk("t4_drop", drop, 1'b1);
    chk("t4_head", out_data, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'd100, 3'b000, 1'b0, 4'd1);
    settle();
    chk("t4_full_pushpop_count", fifo_count, 4'd8);
    for (int k = 0; k < 8; k++) begin
      chk("t4_drain", out_data, 32'(drain_exp[k]));
      idle(1'b1);
      settle();
    end
    chk("t4_empty", out_valid, 1'b0);

    // T6: reset mid-group discards partial sum and clears sticky flags
    samp(24'd7, 4'd4);
    samp(24'd7, 4'd4);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 3'b000, 1'b0, 4'd4);
    for (int i = 0; i < 4; i++) samp(24'd1, 4'd4);
    settle();
    chk("t6_count", fifo_count, 4'd1);
    chk("t6_data", out_data, 32'd4);
    chk("t6_ovf", ovf, 1'b0);
    chk("t6_drop", drop, 1'b0);
    idle(1'b1);

    // clear beats a concurrent sample
    samp(24'd5, 4'd3);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 24'd9, 3'b000, 1'b0, 4'd3);
    settle();
    chk("clr_busy", busy, 1'b0);
    chk("clr_count", fifo_count, 4'd0);
    for (int i = 0; i < 3; i++) samp(24'd1, 4'd3);
    settle();
    chk("clr_data", out_data, 32'd3);
    idle(1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [TW-1:0] cfg;
      cfg = ($urandom_range(0, 3) == 0) ? TW'($urandom_range(0, 15)) : TW'($urandom_range(0, 2));
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
          $urandom_range(0, 199) != 0, PW'($urandom), 3'($urandom), 1'($urandom), cfg);
    end
    idle(1'b1);
    @(negedge RCK);
    chk_en = 1'b0;

    // T5: overflow on the 25-bit accumulator
    @(negedge RCK); #1;
    r25_rstn = 1'b0;
    @(negedge RCK); #1;
    r25_rstn = 1'b1; r25_readyn = 1'b0; r25_ps = 24'h7FFFFF;
    repeat (3) @(posedge RCK);
    #1 r25_readyn = 1'b1;
    #1;
    chk("t5_ovf", ovf25, 1'b1);
    chk("t5_valid", v25, 1'b1);
`ifdef DIMC_COLLECT_SAT_EN
    chk("t5_data", d25, 25'h0FFFFFF);
`else
    chk("t5_data", d25, 25'h17FFFFD);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
